seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed hex driver for an N-digit, common-anode seven-segment display. It consumes the square wave from the clock divider (`scan_clk`) as its digit-scan rate and detects that wave's rising edges synchronously in the `clk_in` domain. It latches a value to display on a load strobe, blanks leading zeros on request and drives active-low anode, segment and decimal-point outputs. It sits between the clock divider / status logic and the board display pins.

## Interface
Parameters:
- `N_DIGITS`, default 8: number of digits scanned; legal range 1..8.

Ports:
- `clk_in`, in, 1: system clock; all logic on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `scan_clk`, in, 1: divided clock from the clock divider; sampled as data, never used as a clock. It is registered in the `clk_in` domain.
- `value`, in, 4*N_DIGITS: hex value to show; nibble i drives digit i, with digit 0 rightmost.
- `load`, in, 1: when high, `value`, `dp_mask` and `blank_lz` are captured into the shadow registers.
- `dp_mask`, in, N_DIGITS: bit i = 1 lights the decimal point of digit i.
- `blank_lz`, in, 1: 1 = blank leading zero digits.
- `anodes_n`, out, N_DIGITS: digit enables, active-low; exactly one bit low after reset.
- `segments_n`, out, 7: active-low segments, ordered {g,f,e,d,c,b,a} (bit 0 = a).
- `dp_n`, out, 1: active-low decimal point.

## Operation
- Edge detect: `scan_prev` <= `scan_clk` every cycle. `scan_tick` = `scan_clk` & ~`scan_prev`.
- Digit index `idx` (3 bits):
  - On `scan_tick`, `idx` <= (`idx` == N_DIGITS-1) ? 0 : `idx`+1.
  - Otherwise `idx` holds.
  - With N_DIGITS = 1, `idx` stays 0.
- Shadow registers: on `load`=1, `sh_value`, `sh_dp` and `sh_blz` are updated from the inputs. Otherwise they hold.
  - `load` and `scan_tick` in the same cycle: both take effect independently.
- Blanking: digit i is blanked when `sh_blz`=1, i != 0, and nibbles i..N_DIGITS-1 of `sh_value` are all zero. Digit 0 is never blanked.
- Output registers are updated every cycle from the current `idx` and shadow registers:
  - `anodes_n` <= ~(1 << `idx`). The anode stays enabled even when the digit is blanked.
  - `segments_n` <= blanked ? 7'h7F : decode(nibble `idx`).
  - `dp_n` <= ~`sh_dp`[`idx`]. The decimal point is NOT suppressed by blanking.
- Decode (hex → `segments_n`):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- `scan_clk` stuck high or low: `idx` freezes and the current digit stays displayed. This is not an error.

## Timing
- Reset values:
  - `scan_prev`=0, `idx`=0, `sh_value`=0, `sh_dp`=0, `sh_blz`=0.
  - `anodes_n`=all 1, `segments_n`=7'h7F, `dp_n`=1 (display dark).
- First cycle after reset deasserts: outputs show digit 0 as "0" (`anodes_n`[0]=0, `segments_n`=7'h40).
- If `scan_clk`=1 when reset releases, `scan_prev`=0 causes one tick in the first cycle.
- Tick latency: `scan_clk` 0→1 sampled at edge k gives `scan_tick` high in cycle k → `idx` updates at edge k+1 → outputs change at edge k+2.
- Load latency: `load` high in cycle k → shadow updated at edge k+1 → outputs reflect the new value at edge k+2.
- One digit advance per `scan_clk` period. For divider parameter d, the digit dwell is d `clk_in` cycles.
- Reset mid-scan: all state returns to its reset values at the next edge with `reset`=1, regardless of `load` or `scan_tick`.

## Test plan
- Reset/idle: assert reset 2 cycles with `scan_clk`=0 → `anodes_n`=FF, `segments_n`=7F, `dp_n`=1. Release → one cycle later `anodes_n`=FE, `segments_n`=40.
- Full scan, N_DIGITS=8, `scan_clk` period 4: load `value`=32'h89ABCDEF, `blank_lz`=0 → digits 0..7 show F,E,d,C,b,A,9,8 (0E,06,21,46,03,08,10,00). The anode then wraps from 7F back to FE.
- Leading-zero blanking: load 32'h00000A05 with `blank_lz`=1 → digits 0..2 show 12,40,08; digits 3..7 show `segments_n`=7F with anodes still cycling. Load 0 → only digit 0 shows 40.
- Decimal point: `dp_mask`=8'h10 with `value`=0 and `blank_lz`=1 → `dp_n`=0 only while `anodes_n`=EF, even though digit 4 is blanked.
- Latency and simultaneity: pulse `load` in the same cycle as the `scan_clk` rising sample → the index advance and the new value both appear at edge k+2. Hold `scan_clk`=1 for 20 cycles → no further advance.
- Reset mid-operation: assert reset while `idx`=5 with `value` loaded → next edge all outputs at reset values. After release, digit 0 shows "0" (shadow cleared).

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed hex driver for a common-anode
// seven-segment display, advancing one digit per scan_clk rising edge.
module seg7_scan_driver #(
   parameter int N_DIGITS = 8
) (
   input  logic                  clk_in,
   input  logic                  reset,
   input  logic                  scan_clk,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic                  load,
   input  logic [N_DIGITS-1:0]   dp_mask,
   input  logic                  blank_lz,
   output logic [N_DIGITS-1:0]   anodes_n,
   output logic [6:0]            segments_n,
   output logic                  dp_n
);

   localparam logic [2:0] LAST_IDX = 3'(N_DIGITS - 1);

   logic                  scan_prev_q;
   logic                  scan_tick;
   logic [2:0]            idx_q;
   logic [2:0]            idx_d;
   logic [4*N_DIGITS-1:0] sh_value_q;
   logic [N_DIGITS-1:0]   sh_dp_q;
   logic                  sh_blz_q;
   logic [N_DIGITS-1:0]   anodes_n_q;
   logic [N_DIGITS-1:0]   anodes_n_d;
   logic [6:0]            seg_n_q;
   logic [6:0]            seg_n_d;
   logic                  dp_n_q;
   logic                  dp_n_d;
   logic [31:0]           val_pad;
   logic [7:0]            dp_pad;
   logic [8:0]            zero_from;
   logic [3:0]            nib;
   logic [7:0]            onehot;
   logic                  blanked;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign scan_tick = scan_clk & ~scan_prev_q;

   always_comb begin
      idx_d = idx_q;
      if (scan_tick) begin
         idx_d = (idx_q == LAST_IDX) ? 3'd0 : idx_q + 3'd1;
      end
   end

   // zero_from[i]: nibbles i and above are all zero (padding counts as zero)
   always_comb begin
      val_pad      = 32'(sh_value_q);
      dp_pad       = 8'(sh_dp_q);
      zero_from    = '0;
      zero_from[8] = 1'b1;
      for (int i = 7; i >= 0; i--) begin
         zero_from[i] = (val_pad[4*i +: 4] == 4'h0) & zero_from[i+1];
      end
   end

   always_comb begin
      nib        = val_pad[{idx_q, 2'b00} +: 4];
      onehot     = 8'd1 << idx_q;
      blanked    = sh_blz_q && (idx_q != 3'd0) && zero_from[{1'b0, idx_q}];
      anodes_n_d = ~onehot[N_DIGITS-1:0];
      seg_n_d    = blanked ? 7'h7F : hex_to_seg(nib);
      dp_n_d     = ~dp_pad[idx_q];
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         scan_prev_q <= 1'b0;
         idx_q       <= 3'd0;
         sh_value_q  <= '0;
         sh_dp_q     <= '0;
         sh_blz_q    <= 1'b0;
         anodes_n_q  <= '1;
         seg_n_q     <= 7'h7F;
         dp_n_q      <= 1'b1;
      end else begin
         scan_prev_q <= scan_clk;
         idx_q       <= idx_d;
         if (load) begin
            sh_value_q <= value;
            sh_dp_q    <= dp_mask;
            sh_blz_q   <= blank_lz;
         end
         anodes_n_q <= anodes_n_d;
         seg_n_q    <= seg_n_d;
         dp_n_q     <= dp_n_d;
      end
   end

   assign anodes_n   = anodes_n_q;
   assign segments_n = seg_n_q;
   assign dp_n       = dp_n_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for the 8-digit scan driver.
// Expected digit patterns are queued at load time and popped on anode change.
module tb_seg7_scan_driver;

   logic        clk_in;
   logic        reset;
   logic        scan_clk;
   logic [31:0] value;
   logic        load;
   logic [7:0]  dp_mask;
   logic        blank_lz;
   logic [7:0]  anodes_n;
   logic [6:0]  segments_n;
   logic        dp_n;

   typedef struct {
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t     q[$];
   int       tests;
   int       fails;
   bit [1:0] ph;

   seg7_scan_driver #(.N_DIGITS(8)) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .scan_clk   (scan_clk),
      .value      (value),
      .load       (load),
      .dp_mask    (dp_mask),
      .blank_lz   (blank_lz),
      .anodes_n   (anodes_n),
      .segments_n (segments_n),
      .dp_n       (dp_n)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   function automatic logic [6:0] dec(input logic [3:0] h);
      case (h)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h08;
         4'hB: return 7'h03;
         4'hC: return 7'h46;
         4'hD: return 7'h21;
         4'hE: return 7'h06;
         default: return 7'h0E;
      endcase
   endfunction

   function automatic exp_t digit(input logic [31:0] v, input logic [7:0] dp,
                                  input logic blz, input int i);
      exp_t e;
      logic [31:0] upper;
      logic [3:0]  n;
      logic [7:0]  one;
      upper = v >> (4 * i);
      n     = upper[3:0];
      one   = 8'd1 << i;
      e.an  = ~one;
      e.seg = (blz && i != 0 && upper == 32'd0) ? 7'h7F : dec(n);
      e.dp  = ~dp[i];
      return e;
   endfunction

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   // Reset, load a value, and land with digit 0 of that value on the pins.
   task automatic start_with(input logic [31:0] v, input logic [7:0] dp,
                             input logic blz);
      exp_t e;
      reset = 1'b1; scan_clk = 1'b0; load = 1'b0; ph = 2'd0;
      cyc();
      reset = 1'b0; value = v; dp_mask = dp; blank_lz = blz; load = 1'b1;
      cyc();
      load = 1'b0;
      cyc();
      e = digit(v, dp, blz, 0);
      tests++;
      if (anodes_n !== e.an || segments_n !== e.seg || dp_n !== e.dp) begin
         fails++;
         $display("FAIL digit0 %h: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                  v, anodes_n, segments_n, dp_n, e.an, e.seg, e.dp);
      end
   endtask

   task automatic push_scan(input logic [31:0] v, input logic [7:0] dp,
                            input logic blz, input int last);
      for (int i = 1; i <= last; i++) q.push_back(digit(v, dp, blz, i % 8));
   endtask

   // Drive scan_clk with period 4 and compare each new digit to the queue.
   task automatic run_scan(input int budget);
      logic [7:0] last_an;
      exp_t       e;
      int         n;
      last_an = anodes_n;
      n = 0;
      while (q.size() > 0 && n < budget) begin
         scan_clk = ph[1];
         ph++;
         cyc();
         n++;
         if (anodes_n !== last_an) begin
            last_an = anodes_n;
            e = q.pop_front();
            tests++;
            if (anodes_n !== e.an || segments_n !== e.seg || dp_n !== e.dp) begin
               fails++;
               $display("FAIL scan: got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                        anodes_n, segments_n, dp_n, e.an, e.seg, e.dp);
            end
         end
      end
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL scan_timeout: %0d digits still pending, want 0", q.size());
         q.delete();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; scan_clk = 1'b0; load = 1'b0;
      value = '0; dp_mask = '0; blank_lz = 1'b0;
      cyc();
      cyc();
      tests++;
      if (anodes_n !== 8'hFF) begin
         fails++; $display("FAIL rst_an: got %h want ff", anodes_n);
      end
      tests++;
      if (segments_n !== 7'h7F) begin
         fails++; $display("FAIL rst_seg: got %h want 7f", segments_n);
      end
      tests++;
      if (dp_n !== 1'b1) begin
         fails++; $display("FAIL rst_dp: got %b want 1", dp_n);
      end
      reset = 1'b0;
      cyc();
      tests++;
      if (anodes_n !== 8'hFE) begin
         fails++; $display("FAIL rel_an: got %h want fe", anodes_n);
      end
      tests++;
      if (segments_n !== 7'h40) begin
         fails++; $display("FAIL rel_seg: got %h want 40", segments_n);
      end
      tests++;
      if (dp_n !== 1'b1) begin
         fails++; $display("FAIL rel_dp: got %b want 1", dp_n);
      end
   endtask

   task automatic test_full_scan();
      start_with(32'h89ABCDEF, 8'h00, 1'b0);
      push_scan(32'h89ABCDEF, 8'h00, 1'b0, 8);
      run_scan(60);
   endtask

   task automatic test_blanking();
      start_with(32'h00000A05, 8'h00, 1'b1);
      push_scan(32'h00000A05, 8'h00, 1'b1, 8);
      run_scan(60);
      start_with(32'h0, 8'h00, 1'b1);
      push_scan(32'h0, 8'h00, 1'b1, 8);
      run_scan(60);
   endtask

   task automatic test_decimal_point();
      start_with(32'h0, 8'h10, 1'b1);
      push_scan(32'h0, 8'h10, 1'b1, 8);
      run_scan(60);
   endtask

   task automatic test_back_to_back();
      start_with(32'h76543210, 8'h00, 1'b0);
      scan_clk = 1'b1; load = 1'b1; value = 32'h000000F0;
      cyc();
      load = 1'b0;
      tests++;
      if (anodes_n !== 8'hFE || segments_n !== 7'h40) begin
         fails++;
         $display("FAIL sim_k1: got an=%h seg=%h want an=fe seg=40",
                  anodes_n, segments_n);
      end
      cyc();
      tests++;
      if (anodes_n !== 8'hFD || segments_n !== 7'h0E) begin
         fails++;
         $display("FAIL sim_k2: got an=%h seg=%h want an=fd seg=0e",
                  anodes_n, segments_n);
      end
      for (int i = 0; i < 20; i++) begin
         cyc();
         tests++;
         if (anodes_n !== 8'hFD) begin
            fails++; $display("FAIL hold_%0d: got an=%h want fd", i, anodes_n);
         end
      end
      scan_clk = 1'b0;
   endtask

   task automatic test_reset_mid();
      start_with(32'h89ABCDEF, 8'h20, 1'b0);
      push_scan(32'h89ABCDEF, 8'h20, 1'b0, 5);
      run_scan(40);
      tests++;
      if (anodes_n !== 8'hDF || dp_n !== 1'b0) begin
         fails++; $display("FAIL mid_idx5: got an=%h dp=%b want an=df dp=0",
                           anodes_n, dp_n);
      end
      reset = 1'b1; load = 1'b1; value = 32'hFFFFFFFF; dp_mask = 8'hFF;
      cyc();
      tests++;
      if (anodes_n !== 8'hFF || segments_n !== 7'h7F || dp_n !== 1'b1) begin
         fails++;
         $display("FAIL mid_rst: got an=%h seg=%h dp=%b want an=ff seg=7f dp=1",
                  anodes_n, segments_n, dp_n);
      end
      reset = 1'b0; load = 1'b0; scan_clk = 1'b0;
      cyc();
      tests++;
      if (anodes_n !== 8'hFE || segments_n !== 7'h40 || dp_n !== 1'b1) begin
         fails++;
         $display("FAIL mid_rel: got an=%h seg=%h dp=%b want an=fe seg=40 dp=1",
                  anodes_n, segments_n, dp_n);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      ph    = 2'd0;
      test_reset();
      test_full_scan();
      test_blanking();
      test_decimal_point();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
